// File: rtl/store_buffer.sv
// Posted-write store buffer between the MEM-stage store formatter and the
// data-memory write port. Queues byte-enabled store beats in a DEPTH-entry
// FIFO, coalesces a store into the newest entry when both hit the same word,
// drains the head over a ready/valid handshake and flags load RAW hazards.
//
// Ports:
//   iCLK, iRST                  clock, asynchronous active-high reset
//   iWrReq/iWrAddr/iWrData/
//   iWrByteEnable/iWrException  store beat from MEM stage
//   oFull, oEmpty, oCount       occupancy status
//   iRdReq, iRdAddr, oRdHazard  load address check (combinational)
//   oMemWrite/oMemAddr/oMemData/
//   oMemByteEnable, iMemReady   head entry toward data memory
module store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32
) (
    input  logic                     iCLK,
    input  logic                     iRST,
    input  logic                     iWrReq,
    input  logic [AW-1:0]            iWrAddr,
    input  logic [31:0]              iWrData,
    input  logic [3:0]               iWrByteEnable,
    input  logic                     iWrException,
    output logic                     oFull,
    output logic                     oEmpty,
    output logic [$clog2(DEPTH):0]   oCount,
    input  logic                     iRdReq,
    input  logic [AW-1:0]            iRdAddr,
    output logic                     oRdHazard,
    output logic                     oMemWrite,
    output logic [AW-1:0]            oMemAddr,
    output logic [31:0]              oMemData,
    output logic [3:0]               oMemByteEnable,
    input  logic                     iMemReady
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned WW = AW - 2;

    // Entry storage: word address, data, byte enables
    logic [WW-1:0] addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [3:0]    be_q   [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          coalesce;
    logic          alloc;
    logic [PW-1:0] tail_last;
    logic [PW-1:0] wr_idx;
    logic [31:0]   wr_data;
    logic [3:0]    wr_be;

    // Word-granular addressing: the byte offset bits are intentionally ignored
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{iWrAddr[1:0], iRdAddr[1:0]};

    // Push/pop qualification and entry write data
    always_comb begin
        full      = (count_q == CW'(DEPTH));
        empty     = (count_q == '0);
        push      = iWrReq & ~iWrException & (|iWrByteEnable) & ~full;
        pop       = ~empty & iMemReady;
        tail_last = tail_q - PW'(1);
        // With count >= 2 the newest entry is never the head, so it is not on the bus
        coalesce  = push & (count_q >= CW'(2)) & (addr_q[tail_last] == iWrAddr[AW-1:2]);
        alloc     = push & ~coalesce;

        wr_idx  = tail_q;
        wr_data = iWrData;
        wr_be   = iWrByteEnable;
        if (coalesce) begin
            wr_idx = tail_last;
            wr_be  = be_q[tail_last] | iWrByteEnable;
            for (int unsigned j = 0; j < 4; j++) begin
                wr_data[j*8 +: 8] = iWrByteEnable[j] ? iWrData[j*8 +: 8]
                                                     : data_q[tail_last][j*8 +: 8];
            end
        end
    end

    // Pointer and count next state
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop) begin
            head_d = head_q + PW'(1);
        end
        if (alloc) begin
            tail_d = tail_q + PW'(1);
        end
        case ({alloc, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer/count registers
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage write (allocate at tail or merge into newest entry)
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                be_q[i]   <= '0;
            end
        end else if (push) begin
            addr_q[wr_idx] <= iWrAddr[AW-1:2];
            data_q[wr_idx] <= wr_data;
            be_q[wr_idx]   <= wr_be;
        end
    end

    // Load hazard: any valid entry (including the one popping now) on the same word
    always_comb begin
        logic [PW-1:0] idx;
        logic          hit;
        hit = 1'b0;
        idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if ((CW'(i) < count_q) && (addr_q[idx] == iRdAddr[AW-1:2])) begin
                hit = 1'b1;
            end
        end
        oRdHazard = iRdReq & hit;
    end

    // Memory-side outputs come from registered state only; zero when empty
    always_comb begin
        oFull          = full;
        oEmpty         = empty;
        oCount         = count_q;
        oMemWrite      = ~empty;
        oMemAddr       = '0;
        oMemData       = '0;
        oMemByteEnable = '0;
        if (!empty) begin
            oMemAddr       = {addr_q[head_q], 2'b00};
            oMemData       = data_q[head_q];
            oMemByteEnable = be_q[head_q];
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed, table-driven bench for store_buffer (DEPTH=4, AW=32).
module tb_store_buffer;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iWrReq;
    logic [31:0] iWrAddr;
    logic [31:0] iWrData;
    logic [3:0]  iWrByteEnable;
    logic        iWrException;
    logic        oFull;
    logic        oEmpty;
    logic [2:0]  oCount;
    logic        iRdReq;
    logic [31:0] iRdAddr;
    logic        oRdHazard;
    logic        oMemWrite;
    logic [31:0] oMemAddr;
    logic [31:0] oMemData;
    logic [3:0]  oMemByteEnable;
    logic        iMemReady;

    store_buffer #(.DEPTH(4), .AW(32)) dut (
        .iCLK(iCLK), .iRST(iRST),
        .iWrReq(iWrReq), .iWrAddr(iWrAddr), .iWrData(iWrData),
        .iWrByteEnable(iWrByteEnable), .iWrException(iWrException),
        .oFull(oFull), .oEmpty(oEmpty), .oCount(oCount),
        .iRdReq(iRdReq), .iRdAddr(iRdAddr), .oRdHazard(oRdHazard),
        .oMemWrite(oMemWrite), .oMemAddr(oMemAddr), .oMemData(oMemData),
        .oMemByteEnable(oMemByteEnable), .iMemReady(iMemReady)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        logic        wr;
        logic        exc;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic        rdy;
        logic        rd;
        logic [31:0] raddr;
        logic        e_haz;   // hazard before the edge
        logic [2:0]  e_cnt;   // state after the edge
        logic        e_full;
        logic [31:0] e_maddr;
        logic [31:0] e_mdata;
        logic [3:0]  e_mbe;
    } vec_t;

    vec_t vq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic exc, input logic [31:0] addr,
                                input logic [31:0] data, input logic [3:0] be, input logic rdy,
                                input logic rd, input logic [31:0] raddr, input logic e_haz,
                                input logic [2:0] e_cnt, input logic e_full,
                                input logic [31:0] e_maddr, input logic [31:0] e_mdata,
                                input logic [3:0] e_mbe);
        vec_t v;
        v.wr = wr; v.exc = exc; v.addr = addr; v.data = data; v.be = be;
        v.rdy = rdy; v.rd = rd; v.raddr = raddr; v.e_haz = e_haz;
        v.e_cnt = e_cnt; v.e_full = e_full; v.e_maddr = e_maddr;
        v.e_mdata = e_mdata; v.e_mbe = e_mbe;
        return v;
    endfunction

    // Drive one cycle: check hazard before the edge, state after it
    task automatic apply(input vec_t v, input string tag);
        iWrReq        = v.wr;
        iWrException  = v.exc;
        iWrAddr       = v.addr;
        iWrData       = v.data;
        iWrByteEnable = v.be;
        iMemReady     = v.rdy;
        iRdReq        = v.rd;
        iRdAddr       = v.raddr;
        #1;
        chk({tag, " hazard"}, 32'(oRdHazard), 32'(v.e_haz));
        @(posedge iCLK);
        #1;
        chk({tag, " count"}, 32'(oCount), 32'(v.e_cnt));
        chk({tag, " full"}, 32'(oFull), 32'(v.e_full));
        chk({tag, " empty"}, 32'(oEmpty), 32'(v.e_cnt == 3'd0));
        chk({tag, " memwrite"}, 32'(oMemWrite), 32'(v.e_cnt != 3'd0));
        chk({tag, " memaddr"}, oMemAddr, v.e_maddr);
        chk({tag, " memdata"}, oMemData, v.e_mdata);
        chk({tag, " membe"}, 32'(oMemByteEnable), 32'(v.e_mbe));
    endtask

    initial begin
        // wr exc addr data be rdy rd raddr | haz cnt full maddr mdata mbe
        // Single store, popped next edge; popping entry still raises hazard
        vq.push_back(mk(1,0,32'h100,32'hAABBCCDD,4'hF,1,0,32'h0, 0,3'd1,0,32'h100,32'hAABBCCDD,4'hF));
        vq.push_back(mk(0,0,32'h0,32'h0,4'h0,1,1,32'h100, 1,3'd0,0,32'h0,32'h0,4'h0));
        // Fill with backpressure, refused 5th, refused push while full even with pop
        vq.push_back(mk(1,0,32'h10,32'h1,4'hF,0,0,32'h0, 0,3'd1,0,32'h10,32'h1,4'hF));
        vq.push_back(mk(1,0,32'h14,32'h2,4'hF,0,0,32'h0, 0,3'd2,0,32'h10,32'h1,4'hF));
        vq.push_back(mk(1,0,32'h18,32'h3,4'hF,0,0,32'h0, 0,3'd3,0,32'h10,32'h1,4'hF));
        vq.push_back(mk(1,0,32'h1C,32'h4,4'hF,0,0,32'h0, 0,3'd4,1,32'h10,32'h1,4'hF));
        vq.push_back(mk(1,0,32'h20,32'h5,4'hF,0,0,32'h0, 0,3'd4,1,32'h10,32'h1,4'hF));
        vq.push_back(mk(1,0,32'h20,32'h5,4'hF,1,0,32'h0, 0,3'd3,0,32'h14,32'h2,4'hF));
        vq.push_back(mk(0,0,32'h0,32'h0,4'h0,1,0,32'h0, 0,3'd2,0,32'h18,32'h3,4'hF));
        vq.push_back(mk(0,0,32'h0,32'h0,4'h0,1,0,32'h0, 0,3'd1,0,32'h1C,32'h4,4'hF));
        vq.push_back(mk(0,0,32'h0,32'h0,4'h0,1,0,32'h0, 0,3'd0,0,32'h0,32'h0,4'h0));
        // Coalesce into tail, then coalesce again while the head pops
        vq.push_back(mk(1,0,32'h200,32'h11111111,4'h1,0,0,32'h0, 0,3'd1,0,32'h200,32'h11111111,4'h1));
        vq.push_back(mk(1,0,32'h300,32'h33333333,4'hF,0,0,32'h0, 0,3'd2,0,32'h200,32'h11111111,4'h1));
        vq.push_back(mk(1,0,32'h302,32'h22222222,4'hC,0,0,32'h0, 0,3'd2,0,32'h200,32'h11111111,4'h1));
        vq.push_back(mk(1,0,32'h300,32'h55555555,4'h1,1,0,32'h0, 0,3'd1,0,32'h300,32'h22223355,4'hF));
        vq.push_back(mk(0,0,32'h0,32'h0,4'h0,1,0,32'h0, 0,3'd0,0,32'h0,32'h0,4'h0));
        // Count==1: same word allocates instead of touching the head; push+pop net zero
        vq.push_back(mk(1,0,32'h500,32'h000000AA,4'h1,0,0,32'h0, 0,3'd1,0,32'h500,32'h000000AA,4'h1));
        vq.push_back(mk(1,0,32'h500,32'h0000BB00,4'h2,0,0,32'h0, 0,3'd2,0,32'h500,32'h000000AA,4'h1));
        vq.push_back(mk(0,0,32'h0,32'h0,4'h0,1,0,32'h0, 0,3'd1,0,32'h500,32'h0000BB00,4'h2));
        vq.push_back(mk(1,0,32'h604,32'h66,4'hF,1,0,32'h0, 0,3'd1,0,32'h604,32'h66,4'hF));
        vq.push_back(mk(0,0,32'h0,32'h0,4'h0,1,0,32'h0, 0,3'd0,0,32'h0,32'h0,4'h0));
        // Dropped beats: exception, zero byte enable
        vq.push_back(mk(1,1,32'h700,32'h77,4'hF,0,0,32'h0, 0,3'd0,0,32'h0,32'h0,4'h0));
        vq.push_back(mk(1,0,32'h700,32'h77,4'h0,0,0,32'h0, 0,3'd0,0,32'h0,32'h0,4'h0));
        // Hazards: same word, next word, same-cycle store excluded, popped entry
        vq.push_back(mk(1,0,32'h400,32'h44,4'hF,0,0,32'h0, 0,3'd1,0,32'h400,32'h44,4'hF));
        vq.push_back(mk(0,0,32'h0,32'h0,4'h0,0,1,32'h403, 1,3'd1,0,32'h400,32'h44,4'hF));
        vq.push_back(mk(0,0,32'h0,32'h0,4'h0,0,1,32'h404, 0,3'd1,0,32'h400,32'h44,4'hF));
        vq.push_back(mk(1,0,32'h404,32'h45,4'hF,0,1,32'h404, 0,3'd2,0,32'h400,32'h44,4'hF));
        vq.push_back(mk(0,0,32'h0,32'h0,4'h0,1,1,32'h404, 1,3'd1,0,32'h404,32'h45,4'hF));
        vq.push_back(mk(0,0,32'h0,32'h0,4'h0,1,1,32'h400, 0,3'd0,0,32'h0,32'h0,4'h0));
        vq.push_back(mk(0,0,32'h0,32'h0,4'h0,0,1,32'h404, 0,3'd0,0,32'h0,32'h0,4'h0));

        // Reset state
        iRST = 1'b1;
        iWrReq = 1'b0; iWrException = 1'b0; iWrAddr = '0; iWrData = '0;
        iWrByteEnable = '0; iMemReady = 1'b0; iRdReq = 1'b0; iRdAddr = '0;
        #1;
        chk("reset empty", 32'(oEmpty), 32'd1);
        chk("reset full", 32'(oFull), 32'd0);
        chk("reset count", 32'(oCount), 32'd0);
        chk("reset memwrite", 32'(oMemWrite), 32'd0);
        chk("reset memaddr", oMemAddr, 32'h0);
        chk("reset hazard", 32'(oRdHazard), 32'd0);
        @(posedge iCLK);
        #1;
        iRST = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            apply(vq[i], $sformatf("v%0d", i));
        end

        // Reset asserted mid-drain with three entries pending
        apply(mk(1,0,32'h800,32'h8,4'hF,0,0,32'h0, 0,3'd1,0,32'h800,32'h8,4'hF), "rst0");
        apply(mk(1,0,32'h804,32'h9,4'hF,0,0,32'h0, 0,3'd2,0,32'h800,32'h8,4'hF), "rst1");
        apply(mk(1,0,32'h808,32'hA,4'hF,0,0,32'h0, 0,3'd3,0,32'h800,32'h8,4'hF), "rst2");
        iWrReq = 1'b0;
        iRdReq = 1'b1;
        iRdAddr = 32'h800;
        #2;
        iRST = 1'b1;
        #1;
        chk("midrst memwrite", 32'(oMemWrite), 32'd0);
        chk("midrst count", 32'(oCount), 32'd0);
        chk("midrst empty", 32'(oEmpty), 32'd1);
        chk("midrst memaddr", oMemAddr, 32'h0);
        chk("midrst hazard", 32'(oRdHazard), 32'd0);
        @(posedge iCLK);
        #1;
        iRST = 1'b0;
        iMemReady = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge iCLK);
            #1;
            chk($sformatf("postrst%0d memwrite", k), 32'(oMemWrite), 32'd0);
            chk($sformatf("postrst%0d count", k), 32'(oCount), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer directly downstream of the store formatter in the MEM stage.
- Accepts byte-enabled store beats (replicated data plus 4-bit byte enable) and queues them in a small FIFO.
- Drains the queue to the data-memory write port over a ready/valid handshake, so that memory wait states do not stall the pipeline until the buffer fills.
- Coalesces a store into the newest queued entry when both target the same word, and flags read-after-write hazards for loads.

Parameters:
DEPTH, 4, number of entries; power of two, at least 2
AW, 32, byte-address width

Ports:
iCLK  in  1  core clock
iRST  in  1  asynchronous active-high reset
iWrReq  in  1  store beat valid from MEM stage
iWrAddr  in  AW  byte address; bits [1:0] ignored (word granularity)
iWrData  in  32  lane-replicated store data
iWrByteEnable  in  4  byte-lane enables
iWrException  in  1  misaligned-store flag; beat is discarded when set
oFull  out  1  no free entry; MEM stage must hold the store
oEmpty  out  1  no pending entries
oCount  out  $clog2(DEPTH)+1  pending entry count
iRdReq  in  1  load in MEM stage
iRdAddr  in  AW  load byte address
oRdHazard  out  1  load word matches a pending entry; pipeline stalls
oMemWrite  out  1  head entry valid toward memory
oMemAddr  out  AW  head word address, bits [1:0] = 00
oMemData  out  32  head data
oMemByteEnable  out  4  head byte enables
iMemReady  in  1  memory accepts head this cycle

Behaviour:
- Reset (async, iRST=1): all entries invalid; head, tail and count = 0; oEmpty=1; oFull=0; oMemWrite=0; oMemAddr, oMemData, oMemByteEnable = 0; oRdHazard=0. Pending stores are discarded, including reset asserted mid-drain; memory sees no further write.
- Push condition: iWrReq & !iWrException & (iWrByteEnable != 0) & !oFull. Beats failing this condition are dropped with no state change.
- Coalesce rule: applies when push holds, count >= 2, and the tail entry word address equals iWrAddr[AW-1:2].
  - For each lane with an enable set, the tail entry data byte is overwritten.
  - Tail byte enable becomes old OR new.
  - Count is unchanged.
  - The head entry is never coalesced (it may be on the bus), so count == 1 always allocates a new entry.
- Allocation: a push that does not coalesce writes the entry at tail, advances tail modulo DEPTH, and increments count.
- Drain:
  - oMemWrite = !oEmpty.
  - oMemAddr, oMemData and oMemByteEnable reflect the head entry and stay stable while oMemWrite & !iMemReady.
  - When empty, these outputs are 0.
  - Pop on oMemWrite & iMemReady: head advances modulo DEPTH, count decrements.
- Simultaneous push and pop: count is unchanged (net zero); both pointers advance.
  - oFull uses the pre-edge count, so a push while full is refused even if a pop occurs in the same cycle.
  - Coalescing is evaluated against the pre-edge tail and remains legal during a pop when count >= 2.
- Latency:
  - A store pushed into an empty buffer at edge N appears on oMemWrite after edge N (visible in cycle N+1).
  - No combinational path from iWr* to oMem*.
- oFull = (count == DEPTH); oEmpty = (count == 0).
- oRdHazard is combinational: iRdReq & (some valid entry with word address == iRdAddr[AW-1:2]).
  - Byte lanes are not compared.
  - A same-cycle incoming store is not included.
  - The entry popped this cycle still counts toward the hazard.
- Pointer wrap: head and tail are log2(DEPTH) bits and wrap naturally; count disambiguates full from empty.

Test Plan:
1. Reset then single store: push addr 0x100, data 0xAABBCCDD, BE 1111 with iMemReady=1 -> next cycle oMemWrite=1, oMemAddr=0x100, oMemData=0xAABBCCDD, BE=1111; popped the following edge; oEmpty=1.
2. Fill and backpressure: hold iMemReady=0 and push 5 stores to distinct words -> oFull=1 after the 4th push; the 5th is refused (oCount=4); raising iMemReady drains the 4 entries in FIFO order, one per cycle.
3. Coalesce: iMemReady=0; push 0x200 BE 0001 data 0x11111111, then 0x300 BE 1111, then 0x300+2 BE 1100 data 0x22222222 -> oCount=2; after draining, the second bus write is addr 0x300, BE 1111, upper halfword 0x2222.
4. Exception and zero-BE drop: push with iWrException=1, then with BE=0000 -> oCount stays 0, oMemWrite stays 0.
5. Hazard: entry pending at 0x400; iRdReq=1 with iRdAddr 0x403 -> oRdHazard=1; iRdAddr 0x404 -> oRdHazard=0; oRdHazard=0 once the entry pops.
6. Reset mid-drain: three entries pending with iMemReady=0; assert iRST between edges -> oMemWrite=0, oCount=0 immediately; after release, no stale write appears.
